// File: rtl/cvxif_offload_responder.sv
// Responder end of the CV-X-IF offload interface. It accepts CUSTOM-0 ADD/SUB/XOR/MUL
// instructions, queues them until they are committed or killed, executes them in order
// and returns tagged results.
module cvxif_offload_responder #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned IdWidth    = 3,
  parameter int unsigned Depth      = 4,
  parameter int unsigned MulLatency = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic               busy_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = (MulLatency > 1) ? $clog2(MulLatency) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [4:0]         rd;
    logic [1:0]         op;
    logic [XLEN-1:0]    rs1;
    logic [XLEN-1:0]    rs2;
  } entry_t;

  entry_t             mem [Depth];
  entry_t             new_entry;
  logic [Depth-1:0]   vld, cmt, kil;
  logic [AddrW:0]     wptr, rptr;
  logic [AddrW-1:0]   waddr, head;
  logic               full, empty, dec_ok, push, pop, load, finish;
  logic               hit_new, hit_head, head_cmt, head_kil;
  state_t             state, state_d;
  logic [CntW-1:0]    cnt, cnt_d;
  logic [XLEN-1:0]    op_a, op_b, alu;
  logic [1:0]         op_q;
  logic [IdWidth-1:0] id_q;
  logic [4:0]         rd_q;
  logic               unused_instr;

  assign unused_instr = ^issue_instr_i[31:15];

  assign waddr = wptr[AddrW-1:0];
  assign head  = rptr[AddrW-1:0];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AddrW] != rptr[AddrW]) && (waddr == head);

  // Decode: CUSTOM-0 opcode with funct3 0..3
  assign dec_ok            = (issue_instr_i[6:0] == 7'h0B) && !issue_instr_i[14];
  assign issue_accept_o    = issue_valid_i && dec_ok;
  assign issue_writeback_o = issue_valid_i && dec_ok;
  assign issue_ready_o     = !full;
  assign push              = issue_valid_i && !full && dec_ok;
  assign busy_o            = !empty || (state != IDLE);

  assign new_entry = '{id: issue_id_i, rd: issue_instr_i[11:7], op: issue_instr_i[13:12],
                       rs1: issue_rs1_i, rs2: issue_rs2_i};

  // A commit for the head is honoured in the same cycle so ADD returns two cycles after commit
  assign hit_new  = commit_valid_i && (commit_id_i == issue_id_i);
  assign hit_head = commit_valid_i && vld[head] && (commit_id_i == mem[head].id);
  assign head_cmt = cmt[head] || (hit_head && !commit_kill_i);
  assign head_kil = kil[head] || (hit_head && commit_kill_i);

  // Queue payload storage (no reset needed, guarded by vld)
  always_ff @(posedge clk_i) begin
    if (push) mem[waddr] <= new_entry;
  end

  // Queue pointers and per-entry commit/kill flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      vld  <= '0;
      cmt  <= '0;
      kil  <= '0;
    end else begin
      if (commit_valid_i) begin
        for (int i = 0; i < int'(Depth); i++) begin
          if (vld[i] && (mem[i].id == commit_id_i)) begin
            if (commit_kill_i) kil[i] <= 1'b1;
            else               cmt[i] <= 1'b1;
          end
        end
      end
      if (push) begin
        vld[waddr] <= 1'b1;
        cmt[waddr] <= hit_new && !commit_kill_i;
        kil[waddr] <= hit_new && commit_kill_i;
        wptr       <= wptr + (AddrW+1)'(1);
      end
      if (pop) begin
        vld[head] <= 1'b0;
        cmt[head] <= 1'b0;
        kil[head] <= 1'b0;
        rptr      <= rptr + (AddrW+1)'(1);
      end
    end
  end

  // FSM state and latency counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // FSM next-state: drop killed heads, execute committed heads, hold result until taken
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pop     = 1'b0;
    load    = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (head_kil) begin
            pop = 1'b1;
          end else if (head_cmt) begin
            load    = 1'b1;
            state_d = EXEC;
            cnt_d   = (mem[head].op == 2'd3) ? CntW'(MulLatency - 1) : '0;
          end
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          pop     = 1'b1;
          finish  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt - CntW'(1);
        end
      end
      RESP: begin
        if (result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU, all operations modulo 2^XLEN
  always_comb begin
    alu = '0;
    case (op_q)
      2'd0:    alu = op_a + op_b;
      2'd1:    alu = op_a - op_b;
      2'd2:    alu = op_a ^ op_b;
      default: alu = op_a * op_b;
    endcase
  end

  // Operand capture on dispatch, result registers held stable through RESP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_a           <= '0;
      op_b           <= '0;
      op_q           <= '0;
      id_q           <= '0;
      rd_q           <= '0;
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_rd_o    <= '0;
      result_data_o  <= '0;
    end else begin
      if (load) begin
        op_a <= mem[head].rs1;
        op_b <= mem[head].rs2;
        op_q <= mem[head].op;
        id_q <= mem[head].id;
        rd_q <= mem[head].rd;
      end
      if (finish) begin
        result_valid_o <= 1'b1;
        result_id_o    <= id_q;
        result_rd_o    <= rd_q;
        result_data_o  <= alu;
      end else if ((state == RESP) && result_ready_i) begin
        result_valid_o <= 1'b0;
      end
    end
  end

endmodule
